// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser, stable-count debounce, edge strobes and hold-to-repeat press strobe
module debounce_bank #(
  parameter int N_CH          = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 32_500_000,
  parameter int REPEAT_PERIOD = 6_500_000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] noisy_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] press_out
);
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RPT} rpt_e;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_e st_q, st_d;
    logic clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, press_q, press_d;
    logic s, done, stop, hit;
    // next-state for synchroniser, debounce counter, edge strobes and repeat timer
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], noisy_in[g]};
      s       = sync_q[SYNC_STAGES-1];
      done    = (s != clean_q) && (cnt_q == CW'(STABLE_CYCLES - 1));
      cnt_d   = (s == clean_q || done) ? '0 : cnt_q + CW'(1);
      clean_d = done ? s : clean_q;
      rise_d  = done & s;
      fall_d  = done & ~s;
      stop    = fall_d | ~repeat_en[g];
      hit     = (st_q == S_WAIT && rcnt_q == RW'(REPEAT_DELAY - 1)) ||
                (st_q == S_RPT && rcnt_q == RW'(REPEAT_PERIOD - 1));
      st_d    = stop ? S_IDLE : st_q == S_IDLE ? (rise_d ? S_WAIT : S_IDLE) : hit ? S_RPT : st_q;
      rcnt_d  = (stop || st_q == S_IDLE || hit) ? '0 : rcnt_q + RW'(1);
      press_d = rise_d | (~stop & hit);
    end
    // state and registered outputs; reset wins over every update
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        rcnt_q  <= '0;
        st_q    <= S_IDLE;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        cnt_q   <= cnt_d;
        rcnt_q  <= rcnt_d;
        st_q    <= st_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        press_q <= press_d;
      end
    end
    assign clean_out[g] = clean_q;
    assign rise_out[g]  = rise_q;
    assign fall_out[g]  = fall_q;
    assign press_out[g] = press_q;
  end
endmodule
